counter_arbiter: RTL and testbench

- Shares the dual-channel event counter (channel 0: +1 per enabled cycle; channel 1: +1 per four enabled cycles) between two requesters.
- Each requester asks for a burst of N increment cycles on its own channel.
- The block grants round-robin and drives the counter's select, enable and clear lines.
- It sits between the requesters and the counter; its outputs connect directly to the counter's Slt, En and Reset inputs.

---
 rtl/counter_arbiter_pkg.sv | 17 +
 rtl/counter_arbiter_rr_arb2.sv | 23 ++
 rtl/counter_arbiter.sv | 134 +++++++++++++
 tb/tb_counter_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_arbiter_pkg.sv
// Shared types and constants for the counter arbiter: FSM encoding,
// channel identifiers and the default burst-length width.
package counter_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  localparam int CNT_W_DEFAULT = 8;

endpackage

// File: rtl/counter_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: a lone request wins outright,
// a tie goes to the channel that was not served last.
module rr_arb2
  import counter_arbiter_pkg::*;
(
  input  logic Req0,
  input  logic Req1,
  input  logic Last,
  output logic Valid,
  output logic Gch
);

  always_comb begin
    Valid = Req0 | Req1;
    Gch   = CH0;
    if (Req0 && Req1) begin
      Gch = ~Last;
    end else if (Req1) begin
      Gch = CH1;
    end
  end

endmodule

// File: rtl/counter_arbiter.sv
// Grants counted bursts on a shared dual-channel event counter to two
// requesters and sequences counter clears; every output is a flop.
module counter_arbiter
  import counter_arbiter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Req0,
  input  logic [CNT_W-1:0] Len0,
  input  logic             Req1,
  input  logic [CNT_W-1:0] Len1,
  input  logic             Clr,
  output logic             Ack0,
  output logic             Ack1,
  output logic             ClrAck,
  output logic             CtrEn,
  output logic             CtrSlt,
  output logic             CtrReset,
  output logic             Busy
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic             last_q, last_d;
  logic             gch_q, gch_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             clr_ack_q, clr_ack_d;
  logic             ctr_en_q, ctr_en_d;
  logic             ctr_slt_q, ctr_slt_d;
  logic             ctr_reset_q, ctr_reset_d;
  logic             busy_q, busy_d;

  logic             arb_valid;
  logic             arb_gch;
  logic [CNT_W-1:0] len_sel;

  rr_arb2 u_rr_arb2 (
    .Req0  (Req0),
    .Req1  (Req1),
    .Last  (last_q),
    .Valid (arb_valid),
    .Gch   (arb_gch)
  );

  // Next-state logic; Clr outranks requests but is only looked at in IDLE,
  // so a clear never cuts a burst short.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    last_d   = last_q;
    gch_d    = gch_q;
    len_sel  = '0;
    case (state_q)
      ST_IDLE: begin
        if (Clr) begin
          state_d = ST_CLEAR;
        end else if (arb_valid) begin
          gch_d   = arb_gch;
          len_sel = (arb_gch == CH1) ? Len1 : Len0;
          if (len_sel != '0) begin
            remain_d = len_sel;
            state_d  = ST_RUN;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_CLEAR: state_d = ST_IDLE;
      ST_RUN: begin
        remain_d = remain_q - CNT_W'(1);
        if (remain_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        last_d  = gch_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state
  // they describe once registered.
  always_comb begin
    ctr_en_d    = (state_d == ST_RUN);
    ctr_slt_d   = (state_d == ST_RUN) ? gch_d : ctr_slt_q;
    ctr_reset_d = (state_d == ST_CLEAR);
    clr_ack_d   = (state_d == ST_CLEAR);
    ack0_d      = (state_d == ST_DONE) && (gch_d == CH0);
    ack1_d      = (state_d == ST_DONE) && (gch_d == CH1);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      remain_q    <= '0;
      last_q      <= CH1;
      gch_q       <= CH0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      clr_ack_q   <= 1'b0;
      ctr_en_q    <= 1'b0;
      ctr_slt_q   <= 1'b0;
      ctr_reset_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remain_q    <= remain_d;
      last_q      <= last_d;
      gch_q       <= gch_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      clr_ack_q   <= clr_ack_d;
      ctr_en_q    <= ctr_en_d;
      ctr_slt_q   <= ctr_slt_d;
      ctr_reset_q <= ctr_reset_d;
      busy_q      <= busy_d;
    end
  end

  assign Ack0     = ack0_q;
  assign Ack1     = ack1_q;
  assign ClrAck   = clr_ack_q;
  assign CtrEn    = ctr_en_q;
  assign CtrSlt   = ctr_slt_q;
  assign CtrReset = ctr_reset_q;
  assign Busy     = busy_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: a scoreboard of expected completion events plus
// a behavioural model of the shared counter driven by the arbiter outputs.
module tb_counter_arbiter;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Req0 = 1'b0, Req1 = 1'b0, Clr = 1'b0;
  logic [7:0] Len0 = '0, Len1 = '0;
  logic       Ack0, Ack1, ClrAck, CtrEn, CtrSlt, CtrReset, Busy;

  counter_arbiter #(.CNT_W(8)) dut (
    .Clk(Clk), .Reset(Reset),
    .Req0(Req0), .Len0(Len0), .Req1(Req1), .Len1(Len1), .Clr(Clr),
    .Ack0(Ack0), .Ack1(Ack1), .ClrAck(ClrAck),
    .CtrEn(CtrEn), .CtrSlt(CtrSlt), .CtrReset(CtrReset), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  // kind: 0 = Ack0, 1 = Ack1, 2 = ClrAck; len = CtrEn cycles before it;
  // slt = CtrSlt seen during those cycles (0 when none); rst = CtrReset with it.
  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] len;
    logic        slt;
    logic        rst;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_ev[0:63];
  int  obs_wr = 0;
  int  obs_rd = 0;
  int  tests = 0;
  int  fails = 0;

  // Reference counter model and event monitor
  int  out0 = 0, out1 = 0, pre1 = 0, en_run = 0;
  bit  run_slt = 1'b0;
  bit  excl_bad = 1'b0;

  always @(negedge Clk) begin
    if (!Reset) begin
      en_run  = 0;
      run_slt = 1'b0;
    end else begin
      if (CtrReset) begin
        out0 = 0; out1 = 0; pre1 = 0;
      end else if (CtrEn) begin
        if (!CtrSlt) out0 = out0 + 1;
        else begin
          pre1 = pre1 + 1;
          if (pre1 == 4) begin pre1 = 0; out1 = out1 + 1; end
        end
      end
      if (CtrEn) begin
        en_run  = en_run + 1;
        run_slt = CtrSlt;
      end
      if ($countones({Ack0, Ack1, ClrAck}) > 1) excl_bad = 1'b1;
      if ((Ack0 || Ack1 || ClrAck) && obs_wr < 64) begin
        obs_ev[obs_wr] = '{kind: (Ack1 ? 2'd1 : (ClrAck ? 2'd2 : 2'd0)),
                           len: 16'(en_run), slt: run_slt, rst: CtrReset};
        obs_wr  = obs_wr + 1;
        en_run  = 0;
        run_slt = 1'b0;
      end
    end
  end

  // Waits for the next completion event, drops the matching request line,
  // and hands the observed event back.
  task automatic serve(input bit keep0, output ev_t e);
    int n;
    n = 0;
    e = '{kind: 2'd3, len: 16'hffff, slt: 1'b0, rst: 1'b0};
    while (obs_wr <= obs_rd && n < 400) begin
      @(negedge Clk); #1;
      n++;
    end
    if (obs_wr <= obs_rd) begin
      tests++; fails++;
      $display("FAIL serve_timeout: no completion event within %0d cycles, wanted 1", n);
    end else begin
      e = obs_ev[obs_rd];
      obs_rd++;
      if (e.kind == 2'd0 && !keep0) Req0 = 1'b0;
      if (e.kind == 2'd1) Req1 = 1'b0;
      if (e.kind == 2'd2) Clr = 1'b0;
    end
  endtask

  task automatic hard_reset();
    @(negedge Clk); #1;
    Reset = 1'b0;
    @(negedge Clk); #1;
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge Clk); #1;
    tests++;
    if ({Ack0, Ack1, ClrAck, CtrEn, CtrSlt, CtrReset, Busy} !== 7'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b, wanted 0000000",
               {Ack0, Ack1, ClrAck, CtrEn, CtrSlt, CtrReset, Busy});
    end
    Reset = 1'b1;
    @(negedge Clk); #1;
    tests++;
    if ({Busy, CtrEn, Ack0, Ack1} !== 4'b0) begin
      fails++;
      $display("FAIL reset_idle: got %b, wanted 0000", {Busy, CtrEn, Ack0, Ack1});
    end
    $display("[TB] reset done");
  endtask

  task automatic test_len3();
    ev_t e, x;
    @(negedge Clk); #1;
    Req0 = 1'b1; Len0 = 8'd3;
    exp_q.push_back('{kind: 2'd0, len: 16'd3, slt: 1'b0, rst: 1'b0});
    for (int c = 1; c <= 5; c++) begin
      @(negedge Clk); #1;
      tests++;
      if (CtrEn !== (c <= 3) || Ack0 !== (c == 4) || Busy !== (c <= 4) ||
          (c <= 3 && CtrSlt !== 1'b0)) begin
        fails++;
        $display("FAIL len3_cycle%0d: en=%b slt=%b ack0=%b busy=%b, wanted en=%b slt=0 ack0=%b busy=%b",
                 c, CtrEn, CtrSlt, Ack0, Busy, (c <= 3), (c == 4), (c <= 4));
      end
      if (Ack0) Req0 = 1'b0;
    end
    x = exp_q.pop_front();
    tests++;
    if (obs_wr <= obs_rd) begin
      fails++;
      $display("FAIL len3_event: no event observed, wanted kind %0d", x.kind);
    end else begin
      e = obs_ev[obs_rd]; obs_rd++;
      if (e !== x) begin
        fails++;
        $display("FAIL len3_event: kind=%0d len=%0d slt=%b rst=%b, wanted kind=%0d len=%0d slt=%b rst=%b",
                 e.kind, e.len, e.slt, e.rst, x.kind, x.len, x.slt, x.rst);
      end
    end
    tests++;
    if (out0 !== 3) begin
      fails++;
      $display("FAIL len3_output0: got %0d, wanted 3", out0);
    end
    $display("[TB] ch0 burst len 3: output0=%0d", out0);
  endtask

  task automatic test_len8_ch1();
    ev_t e, x;
    @(negedge Clk); #1;
    Req1 = 1'b1; Len1 = 8'd8;
    exp_q.push_back('{kind: 2'd1, len: 16'd8, slt: 1'b1, rst: 1'b0});
    serve(1'b0, e);
    x = exp_q.pop_front();
    tests++;
    if (e !== x) begin
      fails++;
      $display("FAIL len8_event: kind=%0d len=%0d slt=%b rst=%b, wanted kind=%0d len=%0d slt=%b rst=%b",
               e.kind, e.len, e.slt, e.rst, x.kind, x.len, x.slt, x.rst);
    end
    tests++;
    if (out1 !== 2 || out0 !== 3) begin
      fails++;
      $display("FAIL len8_outputs: output0=%0d output1=%0d, wanted 3 and 2", out0, out1);
    end
    $display("[TB] ch1 burst len 8: output1=%0d", out1);
  endtask

  task automatic test_tie_alternation();
    ev_t e, x;
    hard_reset();
    @(negedge Clk); #1;
    Req0 = 1'b1; Len0 = 8'd2; Req1 = 1'b1; Len1 = 8'd2;
    exp_q.push_back('{kind: 2'd0, len: 16'd2, slt: 1'b0, rst: 1'b0});
    exp_q.push_back('{kind: 2'd1, len: 16'd2, slt: 1'b1, rst: 1'b0});
    exp_q.push_back('{kind: 2'd0, len: 16'd2, slt: 1'b0, rst: 1'b0});
    for (int i = 0; i < 3; i++) begin
      serve(i == 0, e);
      x = exp_q.pop_front();
      tests++;
      if (e !== x) begin
        fails++;
        $display("FAIL tie_event%0d: kind=%0d len=%0d slt=%b, wanted kind=%0d len=%0d slt=%b",
                 i, e.kind, e.len, e.slt, x.kind, x.len, x.slt);
      end
      $display("[TB] tie grant %0d: kind=%0d len=%0d", i, e.kind, e.len);
    end
  endtask

  task automatic test_clr_defer();
    ev_t e, x;
    @(negedge Clk); #1;
    Req0 = 1'b1; Len0 = 8'd5;
    exp_q.push_back('{kind: 2'd0, len: 16'd5, slt: 1'b0, rst: 1'b0});
    exp_q.push_back('{kind: 2'd2, len: 16'd0, slt: 1'b0, rst: 1'b1});
    exp_q.push_back('{kind: 2'd1, len: 16'd4, slt: 1'b1, rst: 1'b0});
    repeat (3) @(negedge Clk);
    #1;
    Clr = 1'b1; Req1 = 1'b1; Len1 = 8'd4;
    for (int i = 0; i < 3; i++) begin
      serve(1'b0, e);
      x = exp_q.pop_front();
      tests++;
      if (e !== x) begin
        fails++;
        $display("FAIL clr_event%0d: kind=%0d len=%0d slt=%b rst=%b, wanted kind=%0d len=%0d slt=%b rst=%b",
                 i, e.kind, e.len, e.slt, e.rst, x.kind, x.len, x.slt, x.rst);
      end
      $display("[TB] clr sequence %0d: kind=%0d len=%0d", i, e.kind, e.len);
    end
    tests++;
    if (out0 !== 0 || out1 !== 1) begin
      fails++;
      $display("FAIL clr_outputs: output0=%0d output1=%0d, wanted 0 and 1", out0, out1);
    end
  endtask

  task automatic test_len_zero();
    ev_t e, x;
    @(negedge Clk); #1;
    tests++;
    if (Busy !== 1'b0) begin
      fails++;
      $display("FAIL len0_pre_busy: got %b, wanted 0", Busy);
    end
    Req0 = 1'b1; Len0 = 8'd0;
    exp_q.push_back('{kind: 2'd0, len: 16'd0, slt: 1'b0, rst: 1'b0});
    @(negedge Clk); #1;
    tests++;
    if (Ack0 !== 1'b1 || CtrEn !== 1'b0 || Busy !== 1'b1) begin
      fails++;
      $display("FAIL len0_ack: ack0=%b en=%b busy=%b, wanted 1 0 1", Ack0, CtrEn, Busy);
    end
    serve(1'b0, e);
    x = exp_q.pop_front();
    tests++;
    if (e !== x) begin
      fails++;
      $display("FAIL len0_event: kind=%0d len=%0d, wanted kind=%0d len=%0d", e.kind, e.len, x.kind, x.len);
    end
    @(negedge Clk); #1;
    tests++;
    if (Busy !== 1'b0 || Ack0 !== 1'b0) begin
      fails++;
      $display("FAIL len0_post: busy=%b ack0=%b, wanted 0 0", Busy, Ack0);
    end
    $display("[TB] len 0 request acked without enable");
  endtask

  task automatic test_reset_mid();
    ev_t e, x;
    @(negedge Clk); #1;
    Req0 = 1'b1; Len0 = 8'd6;
    repeat (3) @(negedge Clk);
    #1;
    tests++;
    if (CtrEn !== 1'b1) begin
      fails++;
      $display("FAIL midrst_running: en=%b, wanted 1", CtrEn);
    end
    Reset = 1'b0;
    #1;
    tests++;
    if ({Ack0, Ack1, ClrAck, CtrEn, CtrSlt, CtrReset, Busy} !== 7'b0) begin
      fails++;
      $display("FAIL midrst_outputs: got %b, wanted 0000000",
               {Ack0, Ack1, ClrAck, CtrEn, CtrSlt, CtrReset, Busy});
    end
    @(negedge Clk); #1;
    Req0 = 1'b0;
    Reset = 1'b1;
    @(negedge Clk); #1;
    tests++;
    if (Busy !== 1'b0) begin
      fails++;
      $display("FAIL midrst_idle: busy=%b, wanted 0", Busy);
    end
    Req0 = 1'b1; Len0 = 8'd1; Req1 = 1'b1; Len1 = 8'd1;
    exp_q.push_back('{kind: 2'd0, len: 16'd1, slt: 1'b0, rst: 1'b0});
    serve(1'b0, e);
    Req1 = 1'b0;
    x = exp_q.pop_front();
    tests++;
    if (e !== x) begin
      fails++;
      $display("FAIL midrst_last: kind=%0d len=%0d, wanted kind=%0d len=%0d", e.kind, e.len, x.kind, x.len);
    end
    repeat (4) @(negedge Clk);
    #1;
    tests++;
    if (obs_wr !== obs_rd || Busy !== 1'b0) begin
      fails++;
      $display("FAIL midrst_quiet: extra events=%0d busy=%b, wanted 0 0", obs_wr - obs_rd, Busy);
    end
    $display("[TB] reset mid-burst recovered, first tie went to kind %0d", e.kind);
  endtask

  task automatic test_exclusive();
    tests++;
    if (excl_bad !== 1'b0) begin
      fails++;
      $display("FAIL ack_exclusive: overlap seen=%b, wanted 0", excl_bad);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d left, wanted 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_len3();
    test_len8_ch1();
    test_tie_alternation();
    test_clr_defer();
    test_len_zero();
    test_reset_mid();
    test_exclusive();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
